// File: rtl/wishbone_arbiter_rr.sv
`default_nettype none
// ============================================================================
// wishbone_arbiter_rr : round-robin owner of one Wishbone B4 Classic bus
//                       shared by NUM_CTRL controllers, optional stall watchdog
// Revision: 1.0
// ============================================================================
module wishbone_arbiter_rr #(
  parameter int NUM_CTRL  = 4,
  parameter int DAT_WIDTH = 8,
  parameter int ADR_WIDTH = 16,
  parameter int TIMEOUT   = 0,
  localparam int GW       = $clog2(NUM_CTRL)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_CTRL-1:0]           c_cyc_i,
  input  logic [NUM_CTRL-1:0]           c_stb_i,
  input  logic [NUM_CTRL-1:0]           c_we_i,
  input  logic [NUM_CTRL*ADR_WIDTH-1:0] c_adr_i,
  input  logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i,
  output logic [DAT_WIDTH-1:0]          c_dat_o,
  output logic [NUM_CTRL-1:0]           c_ack_o,
  output logic [NUM_CTRL-1:0]           c_err_o,
  output logic                          m_cyc_o,
  output logic                          m_stb_o,
  output logic                          m_we_o,
  output logic [ADR_WIDTH-1:0]          m_adr_o,
  output logic [DAT_WIDTH-1:0]          m_dat_o,
  input  logic [DAT_WIDTH-1:0]          m_dat_i,
  input  logic                          m_ack_i,
  output logic [GW-1:0]                 gnt_o,
  output logic                          busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   pick;
  logic [GW:0]     cand;
  logic            busy;
  logic            owner_cyc;
  logic            owner_stb;
  logic            owner_we;
  logic [ADR_WIDTH-1:0] owner_adr;
  logic [DAT_WIDTH-1:0] owner_dat;
  logic            err_pulse;
  logic            ack_fwd;

  assign busy      = (state_q == ST_BUSY);
  assign owner_cyc = c_cyc_i[gnt_q];
  assign owner_stb = c_stb_i[gnt_q];
  assign owner_we  = c_we_i[gnt_q];
  assign owner_adr = c_adr_i[gnt_q*ADR_WIDTH +: ADR_WIDTH];
  assign owner_dat = c_dat_i[gnt_q*DAT_WIDTH +: DAT_WIDTH];

  // Scan from the farthest offset down so the requester nearest ptr wins.
  always_comb begin
    pick = ptr_q;
    cand = '0;
    for (int i = NUM_CTRL - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_CTRL)) cand = cand - (GW+1)'(NUM_CTRL);
      if (c_cyc_i[cand[GW-1:0]]) pick = cand[GW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|c_cyc_i) begin
          state_d = ST_BUSY;
          gnt_d   = pick;
        end
      end
      ST_BUSY: begin
        if (!owner_cyc) begin
          state_d = ST_IDLE;
          ptr_d   = (gnt_q == GW'(NUM_CTRL - 1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          hit;

      // Ack on the threshold cycle takes precedence over the timeout.
      assign hit = busy & owner_stb & ~m_ack_i & (cnt_q == CW'(TIMEOUT - 1));

      always_comb begin
        cnt_d = '0;
        if (busy && owner_stb && !m_ack_i && !hit) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
      end

      assign err_pulse = hit;
    end else begin : g_no_wdog
      assign err_pulse = 1'b0;
    end
  endgenerate

  // A stray ack while the owner's strobe is low (e.g. after a timeout) is dropped.
  assign ack_fwd = busy & m_ack_i & owner_stb;

  always_comb begin
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_adr_o = '0;
    m_dat_o = '0;
    c_ack_o = '0;
    c_err_o = '0;
    if (busy) begin
      m_cyc_o        = owner_cyc;
      m_stb_o        = owner_stb & ~err_pulse;
      m_we_o         = owner_we;
      m_adr_o        = owner_adr;
      m_dat_o        = owner_dat;
      c_ack_o[gnt_q] = ack_fwd;
      c_err_o[gnt_q] = err_pulse;
    end
  end

  assign c_dat_o = m_dat_i;
  assign gnt_o   = gnt_q;
  assign busy_o  = busy;

endmodule
`default_nettype wire
